// File: rtl/demux16.sv
// -----------------------------------------------------------------------------
// demux16 -- one-to-sixteen registered demultiplexer with valid/ready handshakes
//
// A single producer presents one word per transfer together with a 4-bit
// destination index. Each word is steered into a one-entry holding register
// for that destination channel. Each channel then drains independently to its
// own consumer.
//
// Parameters
//   width      data width of every channel in bits (default 32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   producer holds a word
//   in_ready   word is accepted this cycle when in_valid is also high
//   in_sel     destination channel index, 0-15
//   in_data    word to deliver
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k occupies bits [k*width +: width]
//   pending    number of channels currently holding a word, 0-16
//
// Build option
//   DEMUX16_PASSTHRU_EN  when defined, a full channel that is draining this
//                        cycle can accept a new word in the same cycle, so one
//                        channel sustains one word per cycle. This adds a
//                        combinational path from out_ready to in_ready. When
//                        undefined, a channel must be empty before it is
//                        refilled, and in_ready depends only on in_sel and the
//                        full flags.
// -----------------------------------------------------------------------------
module demux16 #(
  parameter int width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_sel,
  input  logic [width-1:0]      in_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ready,
  output logic [16*width-1:0]   out_data,
  output logic [4:0]            pending
);

  localparam int NCH = 16;

  // Counts the set bits of a 16-bit channel mask.
  function automatic logic [4:0] popcount16(input logic [NCH-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < NCH; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Per-channel holding state.
  logic [NCH-1:0]   full_p0;
  logic [width-1:0] data_p0 [NCH];
  logic [4:0]       pending_p0;

  // Per-cycle control decode.
  logic             sel_full;
  logic             sel_drain;
  logic             accept;
  logic             fill_new;
  logic [NCH-1:0]   fill_oh;
  logic [NCH-1:0]   drain;
  logic [NCH-1:0]   empties;
  logic [NCH-1:0]   full_nxt;
  logic [4:0]       pending_nxt;

  always_comb begin
    sel_full  = full_p0[in_sel];
    sel_drain = out_ready[in_sel];

`ifdef DEMUX16_PASSTHRU_EN
    // A draining full channel frees its slot at this edge, so it can be
    // refilled in the same cycle.
    in_ready = !sel_full || sel_drain;
`else
    in_ready = !sel_full;
`endif

    accept = in_valid && in_ready;

    fill_oh = '0;
    for (int k = 0; k < NCH; k++) begin
      fill_oh[k] = accept && (in_sel == 4'(k));
    end

    drain = full_p0 & out_ready;

    // Only a write into a previously empty channel raises the count. A drain
    // lowers it unless the same channel is refilled at the same edge.
    fill_new = accept && !sel_full;
    empties  = drain & ~fill_oh;

    full_nxt    = (full_p0 & ~drain) | fill_oh;
    pending_nxt = pending_p0 + {4'd0, fill_new} - popcount16(empties);
  end

  // ---- register stage p0: channel flags, occupancy count, channel data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_p0    <= '0;
      pending_p0 <= 5'd0;
    end else begin
      full_p0    <= full_nxt;
      pending_p0 <= pending_nxt;
    end
  end

  // The data registers also clear on reset so that out_data reads zero out of
  // reset. Otherwise they only change when their channel is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        data_p0[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (fill_oh[k]) begin
          data_p0[k] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_valid = full_p0;
    pending   = pending_p0;
    for (int k = 0; k < NCH; k++) begin
      out_data[k*width +: width] = data_p0[k];
    end
  end

endmodule

// File: tb/tb_demux16.sv
module tb_demux16;

  localparam int W = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_sel;
  logic [W-1:0]    in_data;
  logic [15:0]     out_valid;
  logic [15:0]     out_ready;
  logic [16*W-1:0] out_data;
  logic [4:0]      pending;

  demux16 #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: any handshake visible at the falling edge completes at
  // the next rising edge. The delivered word must match the oldest word queued
  // for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 16; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].ch == 4'(k)) begin
              idx = i;
              break;
            end
          end
          vectors++;
          if (idx < 0) begin
            miscompares++;
            $display("FAIL unexpected_delivery ch%0d: got %h, expected no word", k, out_data[k*W +: W]);
          end else begin
            if (out_data[k*W +: W] !== expq[idx].data) begin
              miscompares++;
              $display("FAIL delivery ch%0d: got %h, expected %h", k, out_data[k*W +: W], expq[idx].data);
            end
            expq.delete(idx);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one cycle; pushes the expectation if it is accepted.
  task automatic xfer(input logic [3:0] sel, input logic [W-1:0] data, output bit acc);
    exp_t e;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      e.ch   = sel;
      e.data = data;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int nacc;
    int ncyc;
    int exp_cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 4'd0;
    in_data   = '0;
    out_ready = '0;

    // Reset and idle.
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_out_data_ch0", out_data[0 +: W], 32'h0);
    chk("rst_out_data_ch15", out_data[15*W +: W], 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    chk("idle_pending", 32'(pending), 32'h0);
    for (int s = 0; s < 16; s++) begin
      in_sel = 4'(s);
      #1;
      chk($sformatf("idle_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
    end
    cycle();

    // Single delivery.
    xfer(4'd5, 32'hDEADBEEF, acc);
    chk("single_accept", 32'(acc), 32'h1);
    chk("single_out_valid", 32'(out_valid), 32'h0020);
    chk("single_data", out_data[5*W +: W], 32'hDEADBEEF);
    chk("single_pending", 32'(pending), 32'h1);
    out_ready = 16'h0020;
    cycle();
    out_ready = '0;
    chk("single_drained_valid", 32'(out_valid), 32'h0);
    chk("single_drained_pending", 32'(pending), 32'h0);

    // Backpressure.
    xfer(4'd3, 32'h3333_0001, acc);
    chk("bp_first_accept", 32'(acc), 32'h1);
    in_valid = 1'b1;
    in_sel   = 4'd3;
    in_data  = 32'h3333_0002;
    #1;
    chk("bp_in_ready_full", 32'(in_ready), 32'h0);
    cycle();
    chk("bp_held_data", out_data[3*W +: W], 32'h3333_0001);
    chk("bp_held_valid", 32'(out_valid), 32'h0008);
    chk("bp_pending", 32'(pending), 32'h1);
    in_valid = 1'b0;
    in_sel   = 4'd4;
    #1;
    chk("bp_in_ready_other", 32'(in_ready), 32'h1);
    out_ready = 16'h0008;
    cycle();
    out_ready = '0;
    chk("bp_drained_pending", 32'(pending), 32'h0);

    // Fill all sixteen channels back to back.
    nacc = 0;
    for (int s = 0; s < 16; s++) begin
      xfer(4'(s), 32'hA000_0000 + 32'(s), acc);
      if (acc) nacc++;
    end
    chk("fill_accepts", 32'(nacc), 32'd16);
    chk("fill_out_valid", 32'(out_valid), 32'hFFFF);
    chk("fill_pending", 32'(pending), 32'd16);
    chk("fill_data_ch10", out_data[10*W +: W], 32'hA000_000A);
    out_ready = 16'hFFFF;
    cycle();
    out_ready = '0;
    chk("drain_all_pending", 32'(pending), 32'h0);
    chk("drain_all_valid", 32'(out_valid), 32'h0);

    // Same-channel stream with the consumer always ready.
    out_ready = 16'h0200;
    nacc = 0;
    ncyc = 0;
    while (nacc < 8 && ncyc < 40) begin
      xfer(4'd9, 32'h9000_0000 + 32'(nacc), acc);
      if (acc) nacc++;
      ncyc++;
    end
`ifdef DEMUX16_PASSTHRU_EN
    exp_cyc = 8;
`else
    exp_cyc = 15;
`endif
    chk("stream_accepts", 32'(nacc), 32'd8);
    chk("stream_cycles", 32'(ncyc), 32'(exp_cyc));
    chk("stream_pending", 32'(pending), 32'h1);
    chk("stream_last_data", out_data[9*W +: W], 32'h9000_0007);
    cycle();
    out_ready = '0;
    chk("stream_end_pending", 32'(pending), 32'h0);

    // Reset mid-traffic.
    xfer(4'd0, 32'h0000_00C0, acc);
    xfer(4'd7, 32'h0000_00C7, acc);
    xfer(4'd15, 32'h0000_00CF, acc);
    chk("mid_out_valid", 32'(out_valid), 32'h8081);
    chk("mid_pending", 32'(pending), 32'h3);
    #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_pending", 32'(pending), 32'h0);
    cycle();
    rst_n = 1'b1;
    out_ready = 16'hFFFF;
    cycle();
    cycle();
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_pending", 32'(pending), 32'h0);
    in_sel = 4'd7;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    out_ready = '0;
    cycle();

    chk("scoreboard_empty", 32'(expq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
